// File: rtl/motion_sequencer_if.sv
// Command bus into the motion sequencer: valid/ready handshake plus the
// fields of one motion command (STOP, DRIVE or STEP).
interface motion_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_type;
  logic        cmd_dirL;
  logic        cmd_dirR;
  logic [15:0] cmd_speedL;
  logic [15:0] cmd_speedR;
  logic [15:0] cmd_degL;
  logic [15:0] cmd_degR;
  logic [23:0] cmd_dur;

  modport master (
    output cmd_valid, cmd_type, cmd_dirL, cmd_dirR, cmd_speedL, cmd_speedR,
           cmd_degL, cmd_degR, cmd_dur,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_type, cmd_dirL, cmd_dirR, cmd_speedL, cmd_speedR,
           cmd_degL, cmd_degR, cmd_dur,
    output cmd_ready
  );
endinterface

// File: rtl/motion_sequencer.sv
// Queues motion commands in a small FIFO and sequences the shared motor-drive
// path between the speed controller and the step controller.
module motion_sequencer #(
  parameter int DEPTH        = 4,
  parameter int STEP_ARM     = 2,
  parameter int STEP_TIMEOUT = 48000000
) (
  input  logic                   WF_CLK,
  input  logic                   rst,
  motion_sequencer_if.slave      cmd,
  input  logic                   abort,
  input  logic                   step_done,
  output logic                   driver_sel,
  output logic                   speedctl_en,
  output logic                   stepctl_en,
  output logic [15:0]            degreeL,
  output logic [15:0]            degreeR,
  output logic [15:0]            speedL,
  output logic [15:0]            speedR,
  output logic                   motorL_dir,
  output logic                   motorR_dir,
  output logic                   busy,
  output logic                   cmd_done,
  output logic                   step_err,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;
  localparam int TW   = $clog2(STEP_TIMEOUT + 1);
  localparam int CNTW = (TW > 24) ? TW : 24;

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_DRIVE      = 3'd1;
  localparam logic [2:0] S_STEP_START = 3'd2;
  localparam logic [2:0] S_STEP_WAIT  = 3'd3;
  localparam logic [2:0] S_STOP       = 3'd4;

  typedef struct packed {
    logic [1:0]  typ;
    logic        dir_l;
    logic        dir_r;
    logic [15:0] spd_l;
    logic [15:0] spd_r;
    logic [15:0] deg_l;
    logic [15:0] deg_r;
    logic [23:0] dur;
  } cmd_t;

  cmd_t            mem_q [DEPTH];
  cmd_t            mem_d [DEPTH];
  cmd_t            entry;
  cmd_t            head;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [2:0]      state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            push, pop, clear_out;

  logic            driver_sel_q, driver_sel_d, speedctl_en_q, speedctl_en_d;
  logic            stepctl_en_q, stepctl_en_d, dir_l_q, dir_l_d, dir_r_q, dir_r_d;
  logic [15:0]     degree_l_q, degree_l_d, degree_r_q, degree_r_d;
  logic [15:0]     speed_l_q, speed_l_d, speed_r_q, speed_r_d;
  logic            busy_q, busy_d, cmd_done_q, cmd_done_d, step_err_q, step_err_d;

  assign entry = '{typ: cmd.cmd_type, dir_l: cmd.cmd_dirL, dir_r: cmd.cmd_dirR,
                   spd_l: cmd.cmd_speedL, spd_r: cmd.cmd_speedR,
                   deg_l: cmd.cmd_degL, deg_r: cmd.cmd_degR, dur: cmd.cmd_dur};
  assign head  = mem_q[rd_ptr_q];

  // Gated by rst so the port reads 0 while reset is held.
  assign cmd.cmd_ready = ~rst & ~abort & (count_q < CW'(DEPTH));
  assign push          = cmd.cmd_valid & cmd.cmd_ready;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    mem_d         = mem_q;
    pop           = 1'b0;
    clear_out     = 1'b0;
    driver_sel_d  = driver_sel_q;
    speedctl_en_d = speedctl_en_q;
    stepctl_en_d  = 1'b0;
    dir_l_d       = dir_l_q;
    dir_r_d       = dir_r_q;
    degree_l_d    = degree_l_q;
    degree_r_d    = degree_r_q;
    speed_l_d     = speed_l_q;
    speed_r_d     = speed_r_q;
    cmd_done_d    = 1'b0;
    step_err_d    = 1'b0;

    if (abort) begin
      state_d   = S_IDLE;
      cnt_d     = '0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      clear_out = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          clear_out = 1'b1;
          if (count_q != '0) begin
            pop           = 1'b1;
            clear_out     = 1'b0;
            cnt_d         = (head.dur == '0) ? CNTW'(1) : CNTW'(head.dur);
            dir_l_d       = head.dir_l;
            dir_r_d       = head.dir_r;
            speed_l_d     = head.spd_l;
            speed_r_d     = head.spd_r;
            degree_l_d    = '0;
            degree_r_d    = '0;
            driver_sel_d  = 1'b0;
            speedctl_en_d = 1'b0;
            case (head.typ)
              2'd1: begin
                state_d       = S_DRIVE;
                speedctl_en_d = 1'b1;
              end
              2'd2: begin
                state_d      = S_STEP_START;
                driver_sel_d = 1'b1;
                stepctl_en_d = 1'b1;
                degree_l_d   = head.deg_l;
                degree_r_d   = head.deg_r;
              end
              default: begin
                state_d   = S_STOP;
                clear_out = 1'b1;
              end
            endcase
          end
        end
        S_DRIVE, S_STOP: begin
          if (cnt_q <= CNTW'(1)) begin
            state_d    = S_IDLE;
            cmd_done_d = 1'b1;
            clear_out  = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        S_STEP_START: begin
          state_d = S_STEP_WAIT;
          cnt_d   = '0;
        end
        S_STEP_WAIT: begin
          // cnt_q counts completed STEP_WAIT cycles; early step_done is stale.
          if (step_done && (cnt_q >= CNTW'(STEP_ARM))) begin
            state_d    = S_IDLE;
            cmd_done_d = 1'b1;
            clear_out  = 1'b1;
          end else if (cnt_q >= CNTW'(STEP_TIMEOUT - 1)) begin
            state_d    = S_IDLE;
            step_err_d = 1'b1;
            clear_out  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d   = S_IDLE;
          clear_out = 1'b1;
        end
      endcase

      if (push) begin
        mem_d[wr_ptr_q] = entry;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end

    if (clear_out) begin
      driver_sel_d  = 1'b0;
      speedctl_en_d = 1'b0;
      dir_l_d       = 1'b0;
      dir_r_d       = 1'b0;
      degree_l_d    = '0;
      degree_r_d    = '0;
      speed_l_d     = '0;
      speed_r_d     = '0;
    end

    busy_d = (state_d != S_IDLE) || (count_d != '0);
  end

  always_ff @(posedge WF_CLK or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      driver_sel_q  <= 1'b0;
      speedctl_en_q <= 1'b0;
      stepctl_en_q  <= 1'b0;
      dir_l_q       <= 1'b0;
      dir_r_q       <= 1'b0;
      degree_l_q    <= '0;
      degree_r_q    <= '0;
      speed_l_q     <= '0;
      speed_r_q     <= '0;
      busy_q        <= 1'b0;
      cmd_done_q    <= 1'b0;
      step_err_q    <= 1'b0;
    end else begin
      mem_q         <= mem_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      driver_sel_q  <= driver_sel_d;
      speedctl_en_q <= speedctl_en_d;
      stepctl_en_q  <= stepctl_en_d;
      dir_l_q       <= dir_l_d;
      dir_r_q       <= dir_r_d;
      degree_l_q    <= degree_l_d;
      degree_r_q    <= degree_r_d;
      speed_l_q     <= speed_l_d;
      speed_r_q     <= speed_r_d;
      busy_q        <= busy_d;
      cmd_done_q    <= cmd_done_d;
      step_err_q    <= step_err_d;
    end
  end

  assign driver_sel  = driver_sel_q;
  assign speedctl_en = speedctl_en_q;
  assign stepctl_en  = stepctl_en_q;
  assign degreeL     = degree_l_q;
  assign degreeR     = degree_r_q;
  assign speedL      = speed_l_q;
  assign speedR      = speed_r_q;
  assign motorL_dir  = dir_l_q;
  assign motorR_dir  = dir_r_q;
  assign busy        = busy_q;
  assign cmd_done    = cmd_done_q;
  assign step_err    = step_err_q;
  assign fifo_count  = count_q;

endmodule

// File: tb/tb_motion_sequencer.sv
// Directed bench for motion_sequencer: drive, step, FIFO fill, step timeout,
// abort flush and asynchronous reset, with hand-computed expectations.
module tb_motion_sequencer;
  localparam int DEPTH        = 4;
  localparam int STEP_ARM     = 2;
  localparam int STEP_TIMEOUT = 100;

  logic        WF_CLK = 1'b0;
  logic        rst;
  logic        abort;
  logic        step_done;
  logic        driver_sel, speedctl_en, stepctl_en;
  logic [15:0] degreeL, degreeR, speedL, speedR;
  logic        motorL_dir, motorR_dir, busy, cmd_done, step_err;
  logic [2:0]  fifo_count;

  int n_cmp = 0;
  int n_err = 0;

  motion_sequencer_if cmd_if ();

  motion_sequencer #(
    .DEPTH(DEPTH), .STEP_ARM(STEP_ARM), .STEP_TIMEOUT(STEP_TIMEOUT)
  ) dut (
    .WF_CLK(WF_CLK), .rst(rst), .cmd(cmd_if), .abort(abort), .step_done(step_done),
    .driver_sel(driver_sel), .speedctl_en(speedctl_en), .stepctl_en(stepctl_en),
    .degreeL(degreeL), .degreeR(degreeR), .speedL(speedL), .speedR(speedR),
    .motorL_dir(motorL_dir), .motorR_dir(motorR_dir), .busy(busy),
    .cmd_done(cmd_done), .step_err(step_err), .fifo_count(fifo_count)
  );

  always #5 WF_CLK = ~WF_CLK;

  task automatic tick();
    @(posedge WF_CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected)
    else begin
      n_err++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Offers one command and holds it until accepted (bounded); returns just
  // after the accepting edge.
  task automatic applyStimulus(input logic [1:0] typ, input logic dl, input logic dr,
                               input logic [15:0] sl, input logic [15:0] sr,
                               input logic [15:0] gl, input logic [15:0] gr,
                               input logic [23:0] dur);
    logic got;
    cmd_if.cmd_type   = typ;
    cmd_if.cmd_dirL   = dl;
    cmd_if.cmd_dirR   = dr;
    cmd_if.cmd_speedL = sl;
    cmd_if.cmd_speedR = sr;
    cmd_if.cmd_degL   = gl;
    cmd_if.cmd_degR   = gr;
    cmd_if.cmd_dur    = dur;
    cmd_if.cmd_valid  = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      if (cmd_if.cmd_ready) got = 1'b1;
      tick();
    end
    cmd_if.cmd_valid = 1'b0;
    checkOutput("push_accepted", {31'd0, got}, 32'd1);
  endtask

  task automatic waitDone(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!cmd_done && n < 200);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int en_cnt, done_cnt, done_idx, pulse_cnt, n, busy_seen;
    rst = 1'b1;
    abort = 1'b0;
    step_done = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_type = '0; cmd_if.cmd_dirL = 1'b0; cmd_if.cmd_dirR = 1'b0;
    cmd_if.cmd_speedL = '0; cmd_if.cmd_speedR = '0;
    cmd_if.cmd_degL = '0; cmd_if.cmd_degR = '0; cmd_if.cmd_dur = '0;
    tick(); tick();
    checkOutput("rst_ready", {31'd0, cmd_if.cmd_ready}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_count", {29'd0, fifo_count}, 32'd0);
    checkOutput("rst_speedL", {16'd0, speedL}, 32'd0);
    rst = 1'b0;
    tick();
    checkOutput("ready_after_rst", {31'd0, cmd_if.cmd_ready}, 32'd1);

    // 1: DRIVE 180/180 for 10 clocks
    applyStimulus(2'd1, 1'b0, 1'b0, 16'd180, 16'd180, 16'd0, 16'd0, 24'd10);
    checkOutput("t1_en_at_push", {31'd0, speedctl_en}, 32'd0);
    checkOutput("t1_count_at_push", {29'd0, fifo_count}, 32'd1);
    checkOutput("t1_busy_at_push", {31'd0, busy}, 32'd1);
    tick();
    checkOutput("t1_speedL", {16'd0, speedL}, 32'd180);
    checkOutput("t1_count_popped", {29'd0, fifo_count}, 32'd0);
    en_cnt = 0; done_cnt = 0; done_idx = -1;
    for (int i = 0; i < 20; i++) begin
      en_cnt += int'(speedctl_en);
      done_cnt += int'(cmd_done);
      if (cmd_done && done_idx < 0) done_idx = i;
      tick();
    end
    checkOutput("t1_en_cycles", en_cnt, 32'd10);
    checkOutput("t1_done_pulses", done_cnt, 32'd1);
    checkOutput("t1_done_idx", done_idx, 32'd10);
    checkOutput("t1_busy_after", {31'd0, busy}, 32'd0);

    // 2: STEP 240/120 with step_done held high
    step_done = 1'b1;
    applyStimulus(2'd2, 1'b0, 1'b1, 16'd90, 16'd90, 16'd240, 16'd120, 24'd0);
    tick();
    checkOutput("t2_stepctl_en", {31'd0, stepctl_en}, 32'd1);
    checkOutput("t2_driver_sel", {31'd0, driver_sel}, 32'd1);
    checkOutput("t2_degreeL", {16'd0, degreeL}, 32'd240);
    checkOutput("t2_degreeR", {16'd0, degreeR}, 32'd120);
    checkOutput("t2_dirR", {31'd0, motorR_dir}, 32'd1);
    pulse_cnt = 0; done_idx = -1;
    for (int i = 0; i < 10; i++) begin
      pulse_cnt += int'(stepctl_en);
      if (cmd_done && done_idx < 0) done_idx = i;
      if (i == 3) checkOutput("t2_degreeL_held", {16'd0, degreeL}, 32'd240);
      tick();
    end
    checkOutput("t2_step_pulses", pulse_cnt, 32'd1);
    checkOutput("t2_done_idx", done_idx, 32'd4);
    checkOutput("t2_driver_sel_end", {31'd0, driver_sel}, 32'd0);
    step_done = 1'b0;

    // 3: fill FIFO behind a long DRIVE, then a stalled fifth push
    applyStimulus(2'd1, 1'b0, 1'b0, 16'd10, 16'd10, 16'd0, 16'd0, 24'd30);
    for (int i = 0; i < 4; i++)
      applyStimulus(2'd0, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 24'd5);
    checkOutput("t3_count_full", {29'd0, fifo_count}, 32'd4);
    checkOutput("t3_ready_full", {31'd0, cmd_if.cmd_ready}, 32'd0);
    cmd_if.cmd_type = 2'd1;
    cmd_if.cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    cmd_if.cmd_valid = 1'b0;
    checkOutput("t3_stalled_count", {29'd0, fifo_count}, 32'd4);
    waitDone(n);
    checkOutput("t3_drive_done_count", {29'd0, fifo_count}, 32'd4);
    for (int j = 0; j < 4; j++) begin
      waitDone(n);
      checkOutput("t3_stop_interval", n, 32'd6);
      checkOutput("t3_stop_count", {29'd0, fifo_count}, 32'(3 - j));
    end
    tick();
    checkOutput("t3_busy_end", {31'd0, busy}, 32'd0);

    // 4: STEP timeout with a DRIVE queued behind it
    step_done = 1'b0;
    applyStimulus(2'd2, 1'b0, 1'b0, 16'd20, 16'd20, 16'd90, 16'd90, 24'd0);
    applyStimulus(2'd1, 1'b1, 1'b0, 16'd77, 16'd77, 16'd0, 16'd0, 24'd3);
    n = 0; done_cnt = 0;
    do begin
      tick();
      n++;
      done_cnt += int'(cmd_done);
    end while (!step_err && n < 300);
    checkOutput("t4_err_cycle", n, 32'd101);
    checkOutput("t4_no_done", done_cnt, 32'd0);
    checkOutput("t4_count_at_err", {29'd0, fifo_count}, 32'd1);
    tick();
    checkOutput("t4_err_one_cycle", {31'd0, step_err}, 32'd0);
    checkOutput("t4_next_en", {31'd0, speedctl_en}, 32'd1);
    checkOutput("t4_next_speedL", {16'd0, speedL}, 32'd77);
    checkOutput("t4_next_dirL", {31'd0, motorL_dir}, 32'd1);
    waitDone(n);
    checkOutput("t4_next_len", n, 32'd3);

    // 5: abort mid-DRIVE with three queued; a push during abort is dropped
    tick();
    applyStimulus(2'd1, 1'b0, 1'b0, 16'd55, 16'd55, 16'd0, 16'd0, 24'd50);
    for (int i = 0; i < 3; i++)
      applyStimulus(2'd0, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 24'd5);
    tick(); tick();
    checkOutput("t5_count_pre", {29'd0, fifo_count}, 32'd3);
    checkOutput("t5_en_pre", {31'd0, speedctl_en}, 32'd1);
    abort = 1'b1;
    cmd_if.cmd_type = 2'd1;
    cmd_if.cmd_valid = 1'b1;
    #1;
    checkOutput("t5_ready_abort", {31'd0, cmd_if.cmd_ready}, 32'd0);
    tick();
    checkOutput("t5_en_post", {31'd0, speedctl_en}, 32'd0);
    checkOutput("t5_speedL_post", {16'd0, speedL}, 32'd0);
    checkOutput("t5_count_post", {29'd0, fifo_count}, 32'd0);
    checkOutput("t5_done_post", {31'd0, cmd_done}, 32'd0);
    tick();
    checkOutput("t5_count_held", {29'd0, fifo_count}, 32'd0);
    abort = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    done_cnt = 0; busy_seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      done_cnt += int'(cmd_done);
      busy_seen += int'(busy);
    end
    checkOutput("t5_no_done", done_cnt, 32'd0);
    checkOutput("t5_stay_idle", busy_seen, 32'd0);

    // 6: async reset during STEP_WAIT, then zero-duration DRIVE
    applyStimulus(2'd2, 1'b1, 1'b1, 16'd30, 16'd30, 16'd45, 16'd45, 24'd0);
    tick(); tick(); tick();
    checkOutput("t6_sel_wait", {31'd0, driver_sel}, 32'd1);
    rst = 1'b1;
    #2;
    checkOutput("t6_sel_rst", {31'd0, driver_sel}, 32'd0);
    checkOutput("t6_degreeL_rst", {16'd0, degreeL}, 32'd0);
    checkOutput("t6_speedL_rst", {16'd0, speedL}, 32'd0);
    checkOutput("t6_busy_rst", {31'd0, busy}, 32'd0);
    checkOutput("t6_ready_rst", {31'd0, cmd_if.cmd_ready}, 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();
    applyStimulus(2'd1, 1'b0, 1'b0, 16'd50, 16'd50, 16'd0, 16'd0, 24'd0);
    tick();
    en_cnt = 0; done_idx = -1;
    for (int i = 0; i < 6; i++) begin
      en_cnt += int'(speedctl_en);
      if (cmd_done && done_idx < 0) done_idx = i;
      tick();
    end
    checkOutput("t6_dur0_en", en_cnt, 32'd1);
    checkOutput("t6_dur0_done_idx", done_idx, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
